// File: rtl/laser_pkg.sv
// Shared types and sizes for the laser-coverage job controller.
package laser_pkg;
  localparam int N_POINTS = 40;
  localparam int CW       = 4;
  localparam int PTR_W    = 6;

  typedef enum logic [1:0] {ST_COLLECT, ST_FEED, ST_WAIT, ST_RESULT} state_e;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } point_t;

  typedef struct packed {
    logic [CW-1:0] c1x;
    logic [CW-1:0] c1y;
    logic [CW-1:0] c2x;
    logic [CW-1:0] c2y;
    logic          err;
  } result_t;
endpackage

// File: rtl/laser_pt_buf.sv
// Frame point store: one write port (collect side), one read port (feed side).
module laser_pt_buf #(
  parameter int DEPTH = laser_pkg::N_POINTS
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       we_i,
  input  logic [5:0] wr_ptr_i,
  input  logic [7:0] wr_pt_i,
  input  logic [5:0] rd_ptr_i,
  output logic [7:0] rd_pt_o
);
  import laser_pkg::*;

  point_t mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[wr_ptr_i] <= wr_pt_i;
    end
  end

  assign rd_pt_o = mem_q[rd_ptr_i];
endmodule

// File: rtl/laser_job_ctrl.sv
// Job controller: buffers a frame, replays it into the search core, watches
// for DONE with a watchdog and hands back the centres over valid/ready.
module laser_job_ctrl #(
  parameter int N_POINTS = laser_pkg::N_POINTS,
  parameter int TIMEOUT  = 36000,
  parameter int TMR_W    = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [3:0] in_x_i,
  input  logic [3:0] in_y_i,
  output logic       core_rst_o,
  output logic [3:0] core_x_o,
  output logic [3:0] core_y_o,
  input  logic       core_done_i,
  input  logic [3:0] core_c1x_i,
  input  logic [3:0] core_c1y_i,
  input  logic [3:0] core_c2x_i,
  input  logic [3:0] core_c2y_i,
  output logic       res_valid_o,
  input  logic       res_ready_i,
  output logic [3:0] res_c1x_o,
  output logic [3:0] res_c1y_o,
  output logic [3:0] res_c2x_o,
  output logic [3:0] res_c2y_o,
  output logic       res_err_o,
  output logic       busy_o
);
  import laser_pkg::*;

  localparam logic [PTR_W-1:0] LAST_PT  = PTR_W'(N_POINTS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  result_t           res_q, res_d;
  point_t            rd_pt;
  logic              accept;

  assign accept = in_valid_i && (state_q == ST_COLLECT);

  laser_pt_buf #(.DEPTH(N_POINTS)) u_buf (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .we_i     (accept),
    .wr_ptr_i (wr_ptr_q),
    .wr_pt_i  ({in_x_i, in_y_i}),
    .rd_ptr_i (rd_ptr_q),
    .rd_pt_o  (rd_pt)
  );

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tmr_d    = tmr_q;
    res_d    = res_q;
    case (state_q)
      ST_COLLECT: if (accept) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (wr_ptr_q == LAST_PT) begin
          state_d  = ST_FEED;
          rd_ptr_d = '0;
        end
      end
      ST_FEED: if (rd_ptr_q == LAST_PT) begin
        state_d  = ST_WAIT;
        rd_ptr_d = '0;
        tmr_d    = '0;
      end else begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      ST_WAIT: begin
        tmr_d = tmr_q + TMR_W'(1);
        // DONE takes priority over a watchdog expiry in the same cycle
        if (core_done_i) begin
          res_d.c1x = core_c1x_i;
          res_d.c1y = core_c1y_i;
          res_d.c2x = core_c2x_i;
          res_d.c2y = core_c2y_i;
          res_d.err = 1'b0;
          state_d   = ST_RESULT;
        end else if (tmr_q == TMR_LAST) begin
          res_d     = '0;
          res_d.err = 1'b1;
          state_d   = ST_RESULT;
        end
      end
      ST_RESULT: if (res_ready_i) begin
        wr_ptr_d = '0;
        state_d  = ST_COLLECT;
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_COLLECT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tmr_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tmr_q    <= tmr_d;
      res_q    <= res_d;
    end
  end

  // All handshake/control outputs decode registered state only
  assign in_ready_o  = (state_q == ST_COLLECT);
  assign res_valid_o = (state_q == ST_RESULT);
  assign busy_o      = (state_q == ST_FEED) || (state_q == ST_WAIT);
  assign core_rst_o  = !busy_o;
  assign core_x_o    = (state_q == ST_FEED) ? rd_pt.x : '0;
  assign core_y_o    = (state_q == ST_FEED) ? rd_pt.y : '0;
  assign res_c1x_o   = res_q.c1x;
  assign res_c1y_o   = res_q.c1y;
  assign res_c2x_o   = res_q.c2x;
  assign res_c2y_o   = res_q.c2y;
  assign res_err_o   = res_q.err;
endmodule

// File: tb/tb_laser_job_ctrl.sv
// Randomized bench for laser_job_ctrl with a count-based reference model.
module tb_laser_job_ctrl;
  localparam int NP = 40;
  localparam int TO = 120;

  logic clk = 0, rst_n = 1;
  logic in_valid = 0, core_done = 0, res_ready = 0;
  logic [3:0] in_x = 0, in_y = 0, cc1x = 0, cc1y = 0, cc2x = 0, cc2y = 0;
  logic in_ready, core_rst, res_valid, res_err, busy;
  logic [3:0] core_x, core_y, res_c1x, res_c1y, res_c2x, res_c2y;

  laser_job_ctrl #(.N_POINTS(NP), .TIMEOUT(TO), .TMR_W(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_x_i(in_x), .in_y_i(in_y), .core_rst_o(core_rst), .core_x_o(core_x),
    .core_y_o(core_y), .core_done_i(core_done), .core_c1x_i(cc1x),
    .core_c1y_i(cc1y), .core_c2x_i(cc2x), .core_c2y_i(cc2y),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_c1x_o(res_c1x),
    .res_c1y_o(res_c1y), .res_c2x_o(res_c2x), .res_c2y_o(res_c2y),
    .res_err_o(res_err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // Model: how many points are held, how many have been fed, cycles waited
  int n_acc = 0, fed = 0, waited = 0;
  bit have_res = 0;
  logic [3:0] fx [NP];
  logic [3:0] fy [NP];
  logic [3:0] m_c1x = 0, m_c1y = 0, m_c2x = 0, m_c2y = 0;
  logic m_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_vec();
    bit bsy = (n_acc == NP) && !have_res;
    bit fd  = bsy && (fed < NP);
    int ix  = fd ? fed : 0;
    return {3'b0, (n_acc < NP), !bsy, bsy, have_res,
            fd ? fx[ix] : 4'd0, fd ? fy[ix] : 4'd0,
            m_c1x, m_c1y, m_c2x, m_c2y, m_err};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {3'b0, in_ready, core_rst, busy, res_valid, core_x, core_y,
            res_c1x, res_c1y, res_c2x, res_c2y, res_err};
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      n_acc = 0; fed = 0; waited = 0; have_res = 0;
      m_c1x = 0; m_c1y = 0; m_c2x = 0; m_c2y = 0; m_err = 0;
    end else if (n_acc < NP) begin
      if (in_valid) begin
        fx[n_acc] = in_x; fy[n_acc] = in_y; n_acc++;
      end
    end else if (fed < NP) begin
      fed++; waited = 0;
    end else if (!have_res) begin
      if (core_done) begin
        m_c1x = cc1x; m_c1y = cc1y; m_c2x = cc2x; m_c2y = cc2y; m_err = 0; have_res = 1;
      end else if (waited == TO - 1) begin
        m_c1x = 0; m_c1y = 0; m_c2x = 0; m_c2y = 0; m_err = 1; have_res = 1;
      end else begin
        waited++;
      end
    end else if (res_ready) begin
      have_res = 0; n_acc = 0; fed = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("outputs", dut_vec(), exp_vec());
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // pat 0: x=i%16, y=3i%16; pat 1: random points
  task automatic do_frame(input int pat, input int vpct, input bit spurious);
    int guard = 0;
    while (n_acc < NP && guard < 2000) begin
      in_valid  = ($urandom_range(99) < vpct);
      in_x      = (pat == 0) ? 4'(n_acc % 16) : 4'($urandom);
      in_y      = (pat == 0) ? 4'((3 * n_acc) % 16) : 4'($urandom);
      core_done = spurious ? 1'($urandom_range(1)) : 1'b0;
      cc1x = 4'($urandom); cc1y = 4'($urandom); cc2x = 4'($urandom); cc2y = 4'($urandom);
      res_ready = 1'($urandom_range(1));
      tick(); guard++;
    end
    if (guard >= 2000) chk("frame_bound", 0, 1);
    in_valid = 0; core_done = 0; res_ready = 0;
  endtask

  // Runs feed + wait; DONE is pulsed in the wait cycle whose index is done_at
  task automatic finish_job(input bit spurious, input int done_at,
                            input logic [15:0] cv, output int ticks);
    ticks = 0;
    while (!res_valid && ticks < 1000) begin
      if (n_acc == NP && fed == NP && !have_res) begin
        core_done = (waited == done_at);
        {cc1x, cc1y, cc2x, cc2y} = cv;
      end else begin
        core_done = spurious ? 1'($urandom_range(1)) : 1'b0;
        {cc1x, cc1y, cc2x, cc2y} = 16'($urandom);
      end
      in_valid = 1'($urandom_range(1));
      res_ready = 1'($urandom_range(1));
      tick(); ticks++;
    end
    if (ticks >= 1000) chk("result_bound", 0, 1);
    core_done = 0; in_valid = 0; res_ready = 0;
  endtask

  task automatic take_result(input int hold, input bit lit, input logic [16:0] expv);
    for (int i = 0; i < hold; i++) begin
      res_ready = 0;
      if (lit) chk("res_hold", {res_c1x, res_c1y, res_c2x, res_c2y, res_err}, expv);
      tick();
    end
    res_ready = 1; tick(); res_ready = 0;
  endtask

  int t;

  initial begin
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_ctrl", {in_ready, core_rst, busy, res_valid}, 4'b1100);
    chk("reset_data", {core_x, core_y, res_c1x, res_c1y, res_c2x, res_c2y, res_err}, 0);
    rst_n = 1;
    tick();

    // Known frame, DONE 100 cycles after the last fed point
    do_frame(0, 100, 0);
    chk("ready_drop", in_ready, 0);
    chk("feed0", {core_rst, core_x, core_y}, 9'h000);
    finish_job(0, 99, 16'h34AB, t);
    chk("done_latency", t, 140);
    chk("done_vals", {res_valid, res_c1x, res_c1y, res_c2x, res_c2y, res_err}, {1'b1, 16'h34AB, 1'b0});
    take_result(5, 1, {16'h34AB, 1'b0});

    // Watchdog expiry
    do_frame(1, 100, 0);
    finish_job(0, -1, 16'h0, t);
    chk("timeout_latency", t, NP + TO);
    chk("timeout_vals", {res_c1x, res_c1y, res_c2x, res_c2y, res_err}, 17'h00001);
    chk("timeout_core_rst", core_rst, 1);
    take_result(2, 1, 17'h00001);

    // Sparse valid with spurious DONE pulses in collect/feed
    do_frame(1, 50, 1);
    finish_job(1, $urandom_range(TO - 2), 16'($urandom), t);
    take_result($urandom_range(3), 0, 0);

    // Reset while feeding point 17
    do_frame(1, 70, 0);
    for (int g = 0; g < 100 && fed < 17; g++) tick();
    rst_n = 0;
    #1;
    chk("async_rst_ctrl", {in_ready, core_rst, busy, res_valid}, 4'b1100);
    chk("async_rst_data", {core_x, core_y, res_c1x, res_c1y, res_c2x, res_c2y, res_err}, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    tick();
    chk("no_result_after_rst", res_valid, 0);
    do_frame(0, 100, 0);
    finish_job(0, 50, 16'h1F2E, t);
    chk("post_rst_vals", {res_c1x, res_c1y, res_c2x, res_c2y, res_err}, {16'h1F2E, 1'b0});
    take_result(1, 0, 0);

    // DONE coinciding with the last watchdog cycle
    do_frame(1, 100, 0);
    finish_job(0, TO - 1, 16'h7895, t);
    chk("collide_latency", t, NP + TO);
    chk("collide_vals", {res_c1x, res_c1y, res_c2x, res_c2y, res_err}, {16'h7895, 1'b0});
    take_result(1, 0, 0);

    for (int k = 0; k < 3; k++) begin
      do_frame(1, $urandom_range(30, 100), 1);
      finish_job(1, $urandom_range(TO + 5), 16'($urandom), t);
      take_result($urandom_range(4), 0, 0);
    end

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/laser_job_ctrl.md
# laser_job_ctrl

- Job controller for the laser-coverage search core.
- Accepts a 40-point frame on a valid/ready stream and buffers it.
- Replays the frame into the core's one-point-per-cycle load port under core reset control, then waits for `DONE` with a watchdog.
- Returns the two circle centres (or a timeout error) on a valid/ready result port; sits between the frame source and the search core.

## Interface
- `N_POINTS`, 40: points per frame; must match the core.
- `TIMEOUT`, 36000: max cycles from last fed point to `CORE_DONE`.
- `TMR_W`, 16: watchdog counter width; `TIMEOUT` < 2^`TMR_W`.
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `IN_VALID` in 1: input point valid.
- `IN_READY` out 1: controller accepts a point.
- `IN_X`, `IN_Y` in 4 each: point coordinates.
- `CORE_RST` out 1: active-high reset to the core.
- `CORE_X`, `CORE_Y` out 4 each: point fed to the core.
- `CORE_DONE` in 1: core completion pulse.
- `CORE_C1X`, `CORE_C1Y`, `CORE_C2X`, `CORE_C2Y` in 4 each: core results; valid only in the `CORE_DONE` cycle.
- `RES_VALID` out 1: result valid.
- `RES_READY` in 1: result accepted.
- `RES_C1X`, `RES_C1Y`, `RES_C2X`, `RES_C2Y` out 4 each: captured centres.
- `RES_ERR` out 1: result produced by timeout.
- `BUSY` out 1: high in FEED and WAIT.

## Operation
- FSM states: COLLECT, FEED, WAIT, RESULT. Reset state is COLLECT.
- COLLECT:
  - `IN_READY`=1; `CORE_RST`=1.
  - On `IN_VALID && IN_READY`, write `{IN_X,IN_Y}` to `buf[wr_ptr]` and increment `wr_ptr`.
  - On accepting the point at `wr_ptr==N_POINTS-1`, go to FEED with `rd_ptr`=0.
- FEED:
  - `CORE_RST`=0; `CORE_X/Y`=`buf[rd_ptr]`; `rd_ptr` increments every cycle with no stalls.
  - When `rd_ptr==N_POINTS-1`, go to WAIT and clear `tmr` to 0.
- WAIT:
  - `CORE_RST`=0; `CORE_X/Y` hold 0; `tmr` increments by 1 per cycle.
  - On `CORE_DONE`, capture the four `CORE_C*` inputs into the `RES_C*` registers, set `RES_ERR`=0, go to RESULT.
  - Else, if `tmr==TIMEOUT-1`, clear `RES_C*` to 0, set `RES_ERR`=1, go to RESULT.
  - If `CORE_DONE` and the timeout coincide, `CORE_DONE` wins.
- RESULT:
  - `RES_VALID`=1; `CORE_RST`=1.
  - `RES_*` are stable while `RES_VALID && !RES_READY`.
  - On `RES_READY`, clear `wr_ptr` to 0 and go to COLLECT.
- `CORE_DONE` outside WAIT is ignored.
- `IN_VALID` outside COLLECT is not accepted; `IN_READY`=0.
- Pointers are 6 bits. `wr_ptr` wraps only by the explicit clear. `rd_ptr` never exceeds `N_POINTS-1`.
- Reset mid-job: all state is discarded and `CORE_RST` asserts immediately (asynchronously). The partial frame is lost and no result is emitted.

## Timing
- Reset values:
  - state=COLLECT; `wr_ptr`=`rd_ptr`=`tmr`=0.
  - `IN_READY`=1 (combinational from state).
  - `CORE_RST`=1; `CORE_X`=`CORE_Y`=0.
  - `RES_VALID`=0; `RES_C*`=0; `RES_ERR`=0; `BUSY`=0.
- `IN_READY`, `RES_VALID`, `CORE_RST` and `BUSY` are decoded from registered state; there are no combinational paths from inputs.
- Feed cycle 0 is the first cycle with `CORE_RST`=0, i.e. the cycle after the last input accept. Point i is driven in feed cycle i for exactly one cycle.
- The core completes in about 34.6k cycles after the last point, below the `TIMEOUT` default.
- Result appears (`RES_VALID`=1) the cycle after `CORE_DONE`.
- Minimum gap between the RESULT handshake and the next first accept: 1 cycle (`IN_READY` rises the cycle after `RES_READY`).
- Buffer: 40×8-bit register array. Written only in COLLECT, read only in FEED.

## Structure
- Shared package `laser_pkg`:
  - `N_POINTS`, coordinate width 4;
  - state enum {COLLECT, FEED, WAIT, RESULT};
  - `point_t` {x,y};
  - `result_t` {c1x,c1y,c2x,c2y,err}.
- Natural sub-module: `laser_pt_buf` (40-entry point register array, 1 write / 1 read port, pointer-indexed).
- FSM and watchdog stay in `laser_job_ctrl`.

## Test plan
- Reset then frame: 40 points (x=i%16, y=(3i)%16) with `IN_VALID` always high.
  - `IN_READY` drops after the 40th accept.
  - `CORE_X/Y` show exactly those points on 40 consecutive cycles with `CORE_RST`=0.
- Core model pulses `CORE_DONE` with C1=(3,4), C2=(10,11) 100 cycles after the last feed.
  - `RES_VALID` next cycle with (3,4,10,11), `RES_ERR`=0.
  - With `RES_READY` low for 5 cycles, outputs are held unchanged.
- No `CORE_DONE`, `TIMEOUT`=50.
  - `RES_VALID` rises 50 cycles after WAIT entry with all `RES_C*`=0 and `RES_ERR`=1.
  - `CORE_RST` returns to 1.
- `IN_VALID` toggling 50% during COLLECT.
  - Exactly 40 points are captured in order.
  - A spurious `CORE_DONE` during COLLECT/FEED is ignored: no `RES_VALID`.
- `RST_N` low for 2 cycles during FEED at point 17.
  - `CORE_RST`=1 asynchronously, all outputs at reset values.
  - A fresh 40-point frame is then processed correctly.
- `CORE_DONE` in the same cycle as `tmr==TIMEOUT-1` → `RES_ERR`=0 and the core values are captured.
